// File: rtl/ex_hazard_controller.sv
// Pipeline sequencing controller: multi-cycle Execute sequencing, load-use
// hazard stall, taken-branch squash and a saturating stall-cycle counter.
module ex_hazard_controller #(
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned DIV_LAT = 8,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             validD,
  input  logic [3:0]       rs1D,
  input  logic [3:0]       rs2D,
  input  logic             usesRs1D,
  input  logic             usesRs2D,
  input  logic             validE,
  input  logic [3:0]       rdE,
  input  logic             isWbE,
  input  logic             isLdE,
  input  logic             isMulE,
  input  logic             isDivE,
  input  logic             isModE,
  input  logic             branchTakenE,
  output logic             stallFD,
  output logic [1:0]       stallDE,
  output logic             bubbleDE,
  output logic             flushFD,
  output logic             bubbleEM,
  output logic             exBusy,
  output logic             exDone,
  output logic [CNT_W-1:0] stallCycles
);

  typedef enum logic [1:0] {RUN, BUSY, LAST} state_t;

  localparam logic [7:0] MUL_L = 8'(MUL_LAT);
  localparam logic [7:0] DIV_L = 8'(DIV_LAT);

  state_t           state;
  logic [7:0]       cnt;
  logic [CNT_W-1:0] stall_cnt;

  logic       start;
  logic [7:0] lat;
  logic       mc_stall;
  logic       mc_done;
  logic       load_use;
  logic       br_flush;

  // Decode the multi-cycle start and the hazard conditions for this cycle
  always_comb begin
    start    = (state == RUN) && validE && (isMulE || isDivE || isModE);
    lat      = isMulE ? MUL_L : DIV_L;
    mc_stall = (state == BUSY) || (start && (lat >= 8'd2));
    mc_done  = (state == LAST) || (start && (lat == 8'd1));
    load_use = (state == RUN) && !start && validE && isLdE && isWbE && validD &&
               ((usesRs1D && (rs1D == rdE)) || (usesRs2D && (rs2D == rdE)));
    br_flush = (state == RUN) && !mc_stall && branchTakenE;
  end

  // Pipeline controls: multi-cycle stall beats branch squash beats load-use
  always_comb begin
    stallFD  = 1'b0;
    stallDE  = 2'd0;
    bubbleDE = 1'b0;
    flushFD  = 1'b0;
    bubbleEM = 1'b0;
    exBusy   = 1'b0;
    exDone   = 1'b0;
    if (!reset) begin
      exDone = mc_done;
      if (mc_stall) begin
        stallFD  = 1'b1;
        stallDE  = 2'd2;
        bubbleEM = 1'b1;
        exBusy   = 1'b1;
      end else if (br_flush) begin
        flushFD  = 1'b1;
        bubbleDE = 1'b1;
      end else if (load_use) begin
        stallFD  = 1'b1;
        stallDE  = 2'd1;
        bubbleDE = 1'b1;
      end
    end
  end

  // Multi-cycle sequencer; cnt holds the BUSY cycles still to go
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      case (state)
        RUN: begin
          if (start) begin
            if (lat >= 8'd3) begin
              state <= BUSY;
              cnt   <= lat - 8'd2;
            end else if (lat == 8'd2) begin
              state <= LAST;
            end
          end
        end
        BUSY: begin
          if (cnt == 8'd1) state <= LAST;
          else             cnt   <= cnt - 8'd1;
        end
        LAST:    state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  // Saturating count of cycles in which Fetch was held
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stallFD && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  // Counter register is masked so every output reads 0 during reset
  assign stallCycles = reset ? '0 : stall_cnt;

endmodule

// File: tb/tb_ex_hazard_controller.sv
// Bench for ex_hazard_controller: three instances with different latencies
// and counter widths share one stimulus stream; an occupancy-based model is
// compared every cycle, plus directed literal expectations on instance 0/1.
module tb_ex_hazard_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       validD, usesRs1D, usesRs2D, validE, isWbE, isLdE;
  logic       isMulE, isDivE, isModE, branchTakenE;
  logic [3:0] rs1D, rs2D, rdE;

  logic        sFD[3];
  logic [1:0]  sDE[3];
  logic        bDE[3];
  logic        fFD[3];
  logic        bEM[3];
  logic        bsy[3];
  logic        dne[3];
  logic [15:0] sc[3];
  logic [15:0] sc0;
  logic [2:0]  sc1;
  logic [3:0]  sc2;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  ex_hazard_controller #(.MUL_LAT(3), .DIV_LAT(8), .CNT_W(16)) dut0 (
    .clk(clk), .reset(reset), .validD(validD), .rs1D(rs1D), .rs2D(rs2D),
    .usesRs1D(usesRs1D), .usesRs2D(usesRs2D), .validE(validE), .rdE(rdE),
    .isWbE(isWbE), .isLdE(isLdE), .isMulE(isMulE), .isDivE(isDivE),
    .isModE(isModE), .branchTakenE(branchTakenE), .stallFD(sFD[0]),
    .stallDE(sDE[0]), .bubbleDE(bDE[0]), .flushFD(fFD[0]), .bubbleEM(bEM[0]),
    .exBusy(bsy[0]), .exDone(dne[0]), .stallCycles(sc0));

  ex_hazard_controller #(.MUL_LAT(1), .DIV_LAT(2), .CNT_W(3)) dut1 (
    .clk(clk), .reset(reset), .validD(validD), .rs1D(rs1D), .rs2D(rs2D),
    .usesRs1D(usesRs1D), .usesRs2D(usesRs2D), .validE(validE), .rdE(rdE),
    .isWbE(isWbE), .isLdE(isLdE), .isMulE(isMulE), .isDivE(isDivE),
    .isModE(isModE), .branchTakenE(branchTakenE), .stallFD(sFD[1]),
    .stallDE(sDE[1]), .bubbleDE(bDE[1]), .flushFD(fFD[1]), .bubbleEM(bEM[1]),
    .exBusy(bsy[1]), .exDone(dne[1]), .stallCycles(sc1));

  ex_hazard_controller #(.MUL_LAT(2), .DIV_LAT(4), .CNT_W(4)) dut2 (
    .clk(clk), .reset(reset), .validD(validD), .rs1D(rs1D), .rs2D(rs2D),
    .usesRs1D(usesRs1D), .usesRs2D(usesRs2D), .validE(validE), .rdE(rdE),
    .isWbE(isWbE), .isLdE(isLdE), .isMulE(isMulE), .isDivE(isDivE),
    .isModE(isModE), .branchTakenE(branchTakenE), .stallFD(sFD[2]),
    .stallDE(sDE[2]), .bubbleDE(bDE[2]), .flushFD(fFD[2]), .bubbleEM(bEM[2]),
    .exBusy(bsy[2]), .exDone(dne[2]), .stallCycles(sc2));

  assign sc[0] = sc0;
  assign sc[1] = 16'(sc1);
  assign sc[2] = 16'(sc2);

  task automatic check(input string nm, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // r = Execute cycles the current multi-cycle op still occupies (0 = none)
  int mlat[3] = '{3, 1, 2};
  int dlat[3] = '{8, 2, 4};
  int cmax[3] = '{65535, 7, 15};
  int r[3]    = '{0, 0, 0};
  int cntm[3] = '{0, 0, 0};

  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        int rc, e_sfd, e_sde, e_bde, e_ffd, e_bem, e_bsy, e_dne;
        bit op, busy, lu, br;
        if (reset) begin
          {e_sfd, e_sde, e_bde, e_ffd, e_bem, e_bsy, e_dne} = '0;
        end else begin
          op = validE && (isMulE || isDivE || isModE);
          rc = r[i];
          if (r[i] == 0 && op) rc = isMulE ? mlat[i] : dlat[i];
          busy = (rc >= 2);
          lu = (r[i] == 0) && !op && validE && isLdE && isWbE && validD &&
               ((usesRs1D && rs1D == rdE) || (usesRs2D && rs2D == rdE));
          br = (r[i] == 0) && !busy && branchTakenE;
          e_bsy = int'(busy);
          e_bem = int'(busy);
          e_dne = int'(rc == 1);
          e_ffd = int'(br);
          e_bde = int'(!busy && (br || lu));
          e_sfd = int'(busy || (lu && !br));
          e_sde = busy ? 2 : ((lu && !br) ? 1 : 0);
        end
        check($sformatf("dut%0d.stallFD", i), int'(sFD[i]), e_sfd);
        check($sformatf("dut%0d.stallDE", i), int'(sDE[i]), e_sde);
        check($sformatf("dut%0d.bubbleDE", i), int'(bDE[i]), e_bde);
        check($sformatf("dut%0d.flushFD", i), int'(fFD[i]), e_ffd);
        check($sformatf("dut%0d.bubbleEM", i), int'(bEM[i]), e_bem);
        check($sformatf("dut%0d.exBusy", i), int'(bsy[i]), e_bsy);
        check($sformatf("dut%0d.exDone", i), int'(dne[i]), e_dne);
        check($sformatf("dut%0d.stallCycles", i), int'(sc[i]), reset ? 0 : cntm[i]);
        if (reset) begin
          r[i] = 0;
          cntm[i] = 0;
        end else begin
          r[i] = (rc > 0) ? rc - 1 : 0;
          if (e_sfd == 1 && cntm[i] < cmax[i]) cntm[i]++;
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic clear();
    validD = 0; usesRs1D = 0; usesRs2D = 0; validE = 0; isWbE = 0; isLdE = 0;
    isMulE = 0; isDivE = 0; isModE = 0; branchTakenE = 0;
    rs1D = '0; rs2D = '0; rdE = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_use(input logic [3:0] rd, input logic [3:0] r1, input logic u1,
                          input logic [3:0] r2, input logic u2);
    validE = 1; isLdE = 1; isWbE = 1; rdE = rd;
    validD = 1; rs1D = r1; usesRs1D = u1; rs2D = r2; usesRs2D = u2;
  endtask

  initial begin
    int nb;
    clear();
    reset = 1;
    repeat (3) tick();
    #2;
    check("rst_stallFD", int'(sFD[0]), 0);
    check("rst_stallCycles", int'(sc0), 0);
    reset = 0;
    tick(); tick(); #2;
    check("idle_exBusy", int'(bsy[0]), 0);
    check("idle_stallCycles", int'(sc0), 0);

    // mul: dut0 lat 3, dut1 lat 1, dut2 lat 2
    tick(); validE = 1; isMulE = 1; #2;
    check("mul_t_busy0", int'(bsy[0]), 1);
    check("mul_t_stallDE0", int'(sDE[0]), 2);
    check("mul_t_done1", int'(dne[1]), 1);
    check("mul_t_stallFD1", int'(sFD[1]), 0);
    check("mul_t_busy2", int'(bsy[2]), 1);
    tick(); #2;
    check("mul_t1_busy0", int'(bsy[0]), 1);
    check("mul_t1_done2", int'(dne[2]), 1);
    tick(); #2;
    check("mul_t2_done0", int'(dne[0]), 1);
    check("mul_t2_noretrig0", int'(bsy[0]), 0);
    tick(); clear(); #2;
    check("mul_stallCycles0", int'(sc0), 2);

    // div, lat 8 on dut0
    nb = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k == 0) begin validE = 1; isDivE = 1; end
      #2;
      nb += int'(bsy[0]);
    end
    check("div_done0", int'(dne[0]), 1);
    check("div_busycycles0", nb, 7);
    tick(); clear(); #2;
    check("div_stallCycles0", int'(sc0), 9);

    // load r5, Decode reads rs2=5
    tick(); load_use(4'd5, 4'd3, 1'b1, 4'd5, 1'b1); #2;
    check("lu_stallFD0", int'(sFD[0]), 1);
    check("lu_stallDE0", int'(sDE[0]), 1);
    check("lu_bubbleDE0", int'(bDE[0]), 1);
    tick(); validE = 0; isLdE = 0; isWbE = 0; #2;
    check("lu_cleared0", int'(sFD[0]), 0);
    tick(); load_use(4'd5, 4'd3, 1'b1, 4'd5, 1'b0); #2;
    check("lu_noread0", int'(sFD[0]), 0);
    tick(); load_use(4'd0, 4'd0, 1'b1, 4'd7, 1'b0); #2;
    check("lu_r0_stallDE0", int'(sDE[0]), 1);
    tick(); branchTakenE = 1; #2;
    check("br_flushFD0", int'(fFD[0]), 1);
    check("br_bubbleDE0", int'(bDE[0]), 1);
    check("br_stallFD0", int'(sFD[0]), 0);
    check("br_stallDE0", int'(sDE[0]), 0);
    tick(); clear(); #2;
    check("lu_stallCycles0", int'(sc0), 11);

    // reset in 3rd cycle of a div
    tick(); validE = 1; isDivE = 1;
    tick(); tick(); reset = 1; #2;
    check("rstmid_busy0", int'(bsy[0]), 0);
    check("rstmid_stallCycles0", int'(sc0), 0);
    tick(); reset = 0; clear(); #2;
    check("postrst_busy0", int'(bsy[0]), 0);
    check("postrst_stallFD0", int'(sFD[0]), 0);
    check("postrst_done0", int'(dne[0]), 0);

    // fresh mul after reset
    tick(); validE = 1; isMulE = 1; #2;
    check("mul2_t_busy0", int'(bsy[0]), 1);
    tick(); #2;
    check("mul2_t1_busy0", int'(bsy[0]), 1);
    tick(); #2;
    check("mul2_t2_done0", int'(dne[0]), 1);
    tick(); clear(); #2;
    check("mul2_stallCycles0", int'(sc0), 2);

    // back-to-back 2-cycle divs saturate dut1's 3-bit counter
    for (int k = 0; k < 20; k++) begin
      tick();
      if (k == 0) begin validE = 1; isDivE = 1; end
    end
    tick(); clear(); #2;
    check("sat_stallCycles1", int'(sc1), 7);
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
